// File: rtl/synapse_delay_array.sv
// synapse_delay_array: multi-channel synaptic delay line with per-channel
// delay and weight. Each channel shifts accepted spikes through a MAX_DELAY-bit
// line. The tap at line[delay-1] is registered onto spike_out. psc_out carries
// the summed weight of every channel whose tap fires in that cycle.
//
// Optional feature: define SYNAPSE_REFRACT_EN to add a per-channel refractory
// counter. After an accepted spike, input spikes on that channel are dropped
// for the next REFRACT cycles.
//
// Handshake: there is no valid/ready flow control. spike_in is level-sampled,
// so each cycle it is high counts as one spike. cfg_we is a single-cycle
// write strobe that is always accepted.
module synapse_delay_array #(
  parameter int N_CH           = 4,
  parameter int MAX_DELAY      = 8,
  parameter int WEIGHT_W       = 4,
  parameter int DEFAULT_DELAY  = 3,
  parameter int DEFAULT_WEIGHT = 1,
  parameter int REFRACT        = 2,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int DLY_W = $clog2(MAX_DELAY + 1),
  localparam int PSC_W = WEIGHT_W + $clog2(N_CH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_CH-1:0]     spike_in,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [DLY_W-1:0]    cfg_delay,
  input  logic [WEIGHT_W-1:0] cfg_weight,
  output logic [N_CH-1:0]     spike_out,
  output logic [PSC_W-1:0]    psc_out,
  output logic [N_CH-1:0]     busy
);

  logic [MAX_DELAY-1:0] line     [N_CH];
  logic [DLY_W-1:0]     delay_q  [N_CH];
  logic [WEIGHT_W-1:0]  weight_q [N_CH];

  logic [N_CH-1:0]  cfg_hit;
  logic [N_CH-1:0]  refr_ok;
  logic [N_CH-1:0]  accept;
  logic [N_CH-1:0]  tap;
  logic [PSC_W-1:0] psc_next;
  logic [DLY_W-1:0] cfg_delay_clamped;

  // Decode the write target. An out-of-range cfg_ch matches no channel, so
  // the write is ignored.
  always_comb begin
    cfg_hit = '0;
    for (int i = 0; i < N_CH; i++) begin
      cfg_hit[i] = cfg_we && (cfg_ch == CH_W'(i));
    end
  end

  // Clamp the programmed delay into the legal range 1..MAX_DELAY.
  always_comb begin
    cfg_delay_clamped = cfg_delay;
    if (cfg_delay == '0) begin
      cfg_delay_clamped = DLY_W'(1);
    end else if (cfg_delay > DLY_W'(MAX_DELAY)) begin
      cfg_delay_clamped = DLY_W'(MAX_DELAY);
    end
  end

`ifdef SYNAPSE_REFRACT_EN
  localparam int RC_W = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  logic [RC_W-1:0] refr_cnt [N_CH];

  // Refractory counters: arm on an accepted spike, count down to zero, and
  // clear on a config write to the channel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) refr_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (cfg_hit[i]) begin
          refr_cnt[i] <= '0;
        end else if (accept[i]) begin
          refr_cnt[i] <= RC_W'(REFRACT);
        end else if (refr_cnt[i] != '0) begin
          refr_cnt[i] <= refr_cnt[i] - 1'b1;
        end
      end
    end
  end

  // A channel may accept a spike only when its counter has expired.
  always_comb begin
    refr_ok = '0;
    for (int i = 0; i < N_CH; i++) refr_ok[i] = (refr_cnt[i] == '0);
  end
`else
  // No refractory gating in this build, so every sampled spike passes.
  // A negative REFRACT is meaningless and would block all input.
  if (REFRACT >= 0) begin : g_no_refract
    assign refr_ok = '1;
  end else begin : g_bad_refract
    assign refr_ok = '0;
  end
`endif

  // A spike that coincides with a write to its own channel is discarded.
  assign accept = spike_in & ~cfg_hit & refr_ok;

  // Output tap at line[delay-1], and busy as the OR of the live part of the line.
  always_comb begin
    tap  = '0;
    busy = '0;
    for (int i = 0; i < N_CH; i++) begin
      for (int k = 0; k < MAX_DELAY; k++) begin
        if (DLY_W'(k + 1) == delay_q[i]) tap[i] = line[i][k];
        if (DLY_W'(k + 1) <= delay_q[i]) busy[i] = busy[i] | line[i][k];
      end
    end
  end

  // Sum the weights of the channels whose tap fires. These are pre-write weights.
  always_comb begin
    psc_next = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (tap[i]) psc_next = psc_next + PSC_W'(weight_q[i]);
    end
  end

  // Line shifting, config load with flush, and registered outputs. The
  // outputs use the pre-write tap. A flush therefore first shows up in the
  // following cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spike_out <= '0;
      psc_out   <= '0;
      for (int i = 0; i < N_CH; i++) begin
        line[i]     <= '0;
        delay_q[i]  <= DLY_W'(DEFAULT_DELAY);
        weight_q[i] <= WEIGHT_W'(DEFAULT_WEIGHT);
      end
    end else begin
      spike_out <= tap;
      psc_out   <= psc_next;
      for (int i = 0; i < N_CH; i++) begin
        if (cfg_hit[i]) begin
          line[i]     <= '0;
          delay_q[i]  <= cfg_delay_clamped;
          weight_q[i] <= cfg_weight;
        end else begin
          line[i] <= {line[i][MAX_DELAY-2:0], accept[i]};
        end
      end
    end
  end

endmodule

// File: tb/tb_synapse_delay_array.sv
// tb_synapse_delay_array: directed scenarios followed by random traffic.
// Outputs are compared against an absolute-time emission schedule. A spike
// accepted at edge n with delay d is due at edge n+d.
module tb_synapse_delay_array;

  localparam int N_CH           = 4;
  localparam int MAX_DELAY      = 8;
  localparam int WEIGHT_W       = 4;
  localparam int DEFAULT_DELAY  = 3;
  localparam int DEFAULT_WEIGHT = 1;
  localparam int REFRACT        = 2;
  localparam int CH_W           = 2;
  localparam int DLY_W          = 4;
  localparam int PSC_W          = 7;
  localparam int SCH            = 4096;

  // ---------------- clock / reset / DUT ----------------
  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [N_CH-1:0]     spike_in = '0;
  logic                cfg_we = 1'b0;
  logic [CH_W-1:0]     cfg_ch = '0;
  logic [DLY_W-1:0]    cfg_delay = '0;
  logic [WEIGHT_W-1:0] cfg_weight = '0;
  logic [N_CH-1:0]     spike_out;
  logic [PSC_W-1:0]    psc_out;
  logic [N_CH-1:0]     busy;

  always #5 clk = ~clk;

  synapse_delay_array #(
    .N_CH(N_CH), .MAX_DELAY(MAX_DELAY), .WEIGHT_W(WEIGHT_W),
    .DEFAULT_DELAY(DEFAULT_DELAY), .DEFAULT_WEIGHT(DEFAULT_WEIGHT),
    .REFRACT(REFRACT)
  ) dut (
    .clk(clk), .reset(reset), .spike_in(spike_in), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_delay(cfg_delay), .cfg_weight(cfg_weight),
    .spike_out(spike_out), .psc_out(psc_out), .busy(busy)
  );

  // ---------------- reference model ----------------
  int vectors = 0;
  int miscompares = 0;
  int n = 0;
  bit sched [N_CH][SCH];
  int m_delay  [N_CH];
  int m_weight [N_CH];
  int last_acc [N_CH];
  logic [N_CH-1:0]  exp_out;
  logic [N_CH-1:0]  exp_busy;
  logic [PSC_W-1:0] exp_psc;

  function automatic int clamp_delay(int v);
    if (v == 0) return 1;
    if (v > MAX_DELAY) return MAX_DELAY;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      for (int t = 0; t < SCH; t++) sched[i][t] = 1'b0;
      m_delay[i]  = DEFAULT_DELAY;
      m_weight[i] = DEFAULT_WEIGHT;
      last_acc[i] = -1000;
    end
    exp_out  = '0;
    exp_busy = '0;
    exp_psc  = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit ok;
    exp_out = '0;
    exp_psc = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (sched[i][n]) begin
        exp_out[i] = 1'b1;
        exp_psc = exp_psc + PSC_W'(m_weight[i]);
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      if (cfg_we && int'(cfg_ch) == i) begin
        for (int t = n + 1; t <= n + MAX_DELAY; t++) sched[i][t] = 1'b0;
        m_delay[i]  = clamp_delay(int'(cfg_delay));
        m_weight[i] = int'(cfg_weight);
        last_acc[i] = -1000;
      end else if (spike_in[i]) begin
`ifdef SYNAPSE_REFRACT_EN
        ok = (n - last_acc[i]) > REFRACT;
`else
        ok = 1'b1;
`endif
        if (ok) begin
          sched[i][n + m_delay[i]] = 1'b1;
          last_acc[i] = n;
        end
      end
      exp_busy[i] = 1'b0;
      for (int t = n + 1; t <= n + MAX_DELAY; t++) exp_busy[i] = exp_busy[i] | sched[i][t];
    end
    n++;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_outputs(string tag);
    vectors++;
    assert (spike_out === exp_out) else begin
      miscompares++;
      $error("FAIL %s spike_out edge=%0d got %b expected %b", tag, n, spike_out, exp_out);
    end
    vectors++;
    assert (psc_out === exp_psc) else begin
      miscompares++;
      $error("FAIL %s psc_out edge=%0d got %0d expected %0d", tag, n, psc_out, exp_psc);
    end
    vectors++;
    assert (busy === exp_busy) else begin
      miscompares++;
      $error("FAIL %s busy edge=%0d got %b expected %b", tag, n, busy, exp_busy);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  task automatic idle(int k, string tag);
    spike_in = '0;
    for (int j = 0; j < k; j++) tick(tag);
  endtask

  task automatic cfg_write(int ch, int d, int w, string tag);
    cfg_we     = 1'b1;
    cfg_ch     = CH_W'(ch);
    cfg_delay  = DLY_W'(d);
    cfg_weight = WEIGHT_W'(w);
    tick(tag);
    cfg_we     = 1'b0;
  endtask

  // Assert reset in the low phase, check that it clears immediately, and hold
  // reset across one edge.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_outputs("reset");
    @(posedge clk);
    n++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    do_reset();

    // Defaults: delay 3, weight 1.
    spike_in = 4'b0001; tick("default");
    idle(5, "default");

    // ch2 delay 8 weight 5, three back-to-back spikes.
    cfg_write(2, 8, 5, "cfg_ch2");
    spike_in = 4'b0100; tick("burst"); tick("burst"); tick("burst");
    idle(10, "burst");

    // Coincidence: ch0 d2 w3, ch1 d4 w7 -> psc 10.
    cfg_write(0, 2, 3, "coinc");
    cfg_write(1, 4, 7, "coinc");
    spike_in = 4'b0010; tick("coinc");
    idle(1, "coinc");
    spike_in = 4'b0001; tick("coinc");
    idle(5, "coinc");

    // Flush and clamp: delay 0 stores 1, delay 15 stores MAX_DELAY.
    cfg_write(0, 5, 3, "flush");
    spike_in = 4'b0001; tick("flush");
    idle(1, "flush");
    cfg_write(0, 0, 3, "flush");
    idle(6, "flush");
    spike_in = 4'b0001; tick("clamp_lo");
    idle(3, "clamp_lo");
    cfg_write(0, 15, 2, "clamp_hi");
    spike_in = 4'b0001; tick("clamp_hi");
    idle(10, "clamp_hi");

    // Write coinciding with a tap hit: the pulse uses the old weight 4.
    cfg_write(3, 2, 4, "wr_tap");
    spike_in = 4'b1000; tick("wr_tap");
    idle(1, "wr_tap");
    cfg_write(3, 2, 9, "wr_tap");
    idle(4, "wr_tap");

    // Async reset with three spikes in flight.
    spike_in = 4'b1110; tick("async");
    spike_in = '0;
    do_reset();
    idle(12, "post_reset");

    // Level input held for 6 cycles on ch1.
    spike_in = 4'b0010;
    for (int j = 0; j < 6; j++) tick("hold");
    idle(8, "hold");

    // Random traffic with a mid-run reset.
    for (int it = 0; it < 1500; it++) begin
      if (it == 700) begin
        spike_in = '0;
        cfg_we = 1'b0;
        do_reset();
      end
      spike_in   = N_CH'($urandom_range(0, 15));
      cfg_we     = ($urandom_range(0, 15) == 0);
      cfg_ch     = CH_W'($urandom_range(0, N_CH - 1));
      cfg_delay  = DLY_W'($urandom_range(0, 15));
      cfg_weight = WEIGHT_W'($urandom_range(0, 15));
      tick("random");
    end
    cfg_we = 1'b0;
    idle(MAX_DELAY + 2, "drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
